// File: rtl/trace_pkg.sv
// Shared types and defaults for the instruction trace buffer.
// Imported by the trace FIFO memory and the trace buffer top level.
package trace_pkg;

    typedef enum logic {
        CAPTURE = 1'b0,
        FROZEN  = 1'b1
    } trace_state_e;

    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int INSTR_W             = 32;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace storage array: synchronous write port, asynchronous read port.
// Contents are never reset; validity is tracked by the owner's pointers.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int WIDTH = INSTR_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one accepted trace word per cycle
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_trace_buffer.sv
// Instruction trace FIFO with trigger freeze and sticky overflow.
// Owns pointers, occupancy count, flags and the capture/frozen FSM.
module instr_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int WIDTH = INSTR_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Instruction,
    input  logic             InstrValid,
    input  logic             Enable,
    input  logic             TrigEn,
    input  logic [WIDTH-1:0] TrigMatch,
    input  logic             Clear,
    input  logic             RdReady,
    output logic [WIDTH-1:0] RdData,
    output logic             RdValid,
    output logic [CW-1:0]    Count,
    output logic             Overflow,
    output logic             Frozen
);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic trig_hit;

    assign push_req = InstrValid & Enable & (state_q == CAPTURE);
    assign pop      = RdValid & RdReady;
    assign full     = (count_q == CW'(DEPTH));
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & ~push_ok;
    assign trig_hit = TrigEn & (Instruction == TrigMatch);

    // Next-state: flush on Clear, otherwise advance pointers, count, flags
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Clear) begin
            state_d = CAPTURE;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
            if (push_ok && trig_hit) begin
                state_d = FROZEN;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= CAPTURE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i   (Clk),
        .we_i    (push_ok & ~Clear & ~Rst),
        .waddr_i (wptr_q),
        .wdata_i (Instruction),
        .raddr_i (rptr_q),
        .rdata_o (RdData)
    );

    assign RdValid  = (count_q != '0);
    assign Count    = count_q;
    assign Overflow = ovf_q;
    assign Frozen   = (state_q == FROZEN);

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Self-checking bench for instr_trace_buffer.
// Scoreboard queue of expected words plus table-driven trigger vectors.
module tb_instr_trace_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             Clk;
    logic             Rst;
    logic [WIDTH-1:0] Instruction;
    logic             InstrValid;
    logic             Enable;
    logic             TrigEn;
    logic [WIDTH-1:0] TrigMatch;
    logic             Clear;
    logic             RdReady;
    logic [WIDTH-1:0] RdData;
    logic             RdValid;
    logic [CW-1:0]    Count;
    logic             Overflow;
    logic             Frozen;

    instr_trace_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .Enable      (Enable),
        .TrigEn      (TrigEn),
        .TrigMatch   (TrigMatch),
        .Clear       (Clear),
        .RdReady     (RdReady),
        .RdData      (RdData),
        .RdValid     (RdValid),
        .Count       (Count),
        .Overflow    (Overflow),
        .Frozen      (Frozen)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];
    logic        m_ovf;
    logic        m_frz;

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        te;
        logic        clr;
        logic        rdy;
        int          exp_cnt;
        logic        exp_frz;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, score the pop, update model, check state
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic rdy, input logic clr = 1'b0,
                        input logic te = 1'b0,
                        input logic [31:0] tm = 32'h0,
                        input logic en = 1'b1, input logic rst = 1'b0);
        logic pop, preq, acc;
        InstrValid  = v;
        Instruction = ins;
        RdReady     = rdy;
        Clear       = clr;
        TrigEn      = te;
        TrigMatch   = tm;
        Enable      = en;
        Rst         = rst;
        chk("rdvalid", 32'(RdValid), 32'(sb.size() != 0));
        pop = rdy && (sb.size() != 0);
        if (pop) chk("rddata", RdData, sb[0]);
        if (rst || clr) begin
            sb.delete();
            m_ovf = 1'b0;
            m_frz = 1'b0;
        end else begin
            preq = v && en && !m_frz;
            acc  = preq && (sb.size() < DEPTH || pop);
            if (pop) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(ins);
                if (te && ins == tm) m_frz = 1'b1;
            end
            if (preq && !acc) m_ovf = 1'b1;
        end
        @(posedge Clk);
        #1;
        chk("count", 32'(Count), 32'(sb.size()));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("frozen", 32'(Frozen), 32'(m_frz));
    endtask

    initial begin
        m_ovf = 1'b0;
        m_frz = 1'b0;
        Rst = 1'b1;
        Clear = 1'b0;
        InstrValid = 1'b0;
        Instruction = '0;
        Enable = 1'b1;
        TrigEn = 1'b0;
        TrigMatch = '0;
        RdReady = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("reset_count", 32'(Count), 32'd0);
        chk("reset_rdvalid", 32'(RdValid), 32'd0);
        chk("reset_overflow", 32'(Overflow), 32'd0);
        chk("reset_frozen", 32'(Frozen), 32'd0);

        // Three words in order, then drain
        step(1'b1, 32'h20010005, 1'b0);
        step(1'b1, 32'h20020003, 1'b0);
        step(1'b1, 32'h00221820, 1'b0);
        chk("three_count", 32'(Count), 32'd3);
        chk("three_head", RdData, 32'h20010005);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        chk("drained_rdvalid", 32'(RdValid), 32'd0);

        // Overflow on the 17th word
        for (int i = 1; i <= 17; i++) step(1'b1, 32'h1000 + i, 1'b0);
        chk("full_count", 32'(Count), 32'd16);
        chk("full_overflow", 32'(Overflow), 32'd1);
        chk("full_head", RdData, 32'h1001);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Full FIFO push and pop in the same cycle
        for (int i = 1; i <= 16; i++) step(1'b1, 32'h2000 + i, 1'b0);
        step(1'b1, 32'h2011, 1'b1);
        chk("pushpop_count", 32'(Count), 32'd16);
        chk("pushpop_overflow", 32'(Overflow), 32'd0);
        chk("pushpop_head", RdData, 32'h2002);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
        chk("pushpop_empty", 32'(RdValid), 32'd0);

        // Trigger freeze and Clear alongside a push
        vecs[0] = '{1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'hAC010000, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].vld, vecs[i].instr, vecs[i].rdy, vecs[i].clr,
                 vecs[i].te, 32'hAC010000);
            chk($sformatf("vec%0d_count", i), 32'(Count),
                32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_frozen", i), 32'(Frozen),
                32'(vecs[i].exp_frz));
            chk($sformatf("vec%0d_overflow", i), 32'(Overflow),
                32'(vecs[i].exp_ovf));
        end

        // Reset in the middle of a drain
        for (int i = 0; i < 7; i++) step(1'b1, 32'h3000 + i, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("middrain_count", 32'(Count), 32'd5);
        step(1'b1, 32'h3999, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_rdvalid", 32'(RdValid), 32'd0);
        chk("rst_flags", {30'd0, Overflow, Frozen}, 32'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 3) == 0),
                 32'h5,
                 ($urandom_range(0, 4) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_trace_buffer.md
# instr_trace_buffer

Capture-side counterpart to the processor's `Instruction` output: it samples each fetched 32-bit instruction word into an on-chip FIFO and lets a host or debug reader drain the words through a valid/ready handshake. An optional trigger freezes capture after a matching word, so the trace ends at the event of interest. It sits beside `circuitMother` in the datapath/controller hierarchy and taps the same `Clk` and `Rst`.

## Interface
- `DEPTH`, 16, number of trace entries; power of two, at least 2
- `WIDTH`, 32, instruction word width

- `Clk`  in  1  system clock; all logic is on the rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Instruction`  in  WIDTH  instruction word from the datapath
- `InstrValid`  in  1  `Instruction` is a new word this cycle
- `Enable`  in  1  capture enable; when low, pushes are ignored
- `TrigEn`  in  1  arms trigger compare
- `TrigMatch`  in  WIDTH  trigger instruction value
- `Clear`  in  1  one-cycle flush: empty FIFO, clear flags, unfreeze
- `RdReady`  in  1  reader accepts `RdData` this cycle
- `RdData`  out  WIDTH  oldest stored word
- `RdValid`  out  1  FIFO non-empty
- `Count`  out  $clog2(DEPTH)+1  words stored
- `Overflow`  out  1  sticky; a word was dropped because the FIFO was full
- `Frozen`  out  1  trigger fired; capture stopped

## Operation
- States: CAPTURE and FROZEN.
  - Reset and `Clear` both enter CAPTURE.
  - CAPTURE → FROZEN when an accepted push has `TrigEn`=1 and `Instruction`==`TrigMatch`. The matching word is stored.
  - FROZEN → CAPTURE only on `Clear` or `Rst`.
- Push request: `InstrValid & Enable` while in CAPTURE. In FROZEN, requests are ignored and do not set `Overflow`.
- Pop: `RdValid & RdReady`.
- Push acceptance: a push is accepted when `Count` < DEPTH, or when `Count` = DEPTH and a pop happens in the same cycle.
- Dropped push: a push request that is not accepted is discarded and sets `Overflow`=1 at the next edge.
- A trigger match on a dropped word does not freeze capture.
- Pointers: write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `Count` is updated as +1 on push only, −1 on pop only, and unchanged when both or neither occur.
- Read data: `RdData` is the memory entry at the read pointer (combinational read). When `RdValid`=0, `RdData` holds its last value and is don't-care.
- Priority: `Rst` > `Clear` > push/pop. A push or pop in the same cycle as `Clear` is discarded.
- Reset and `Clear` values: `RdValid`=0, `Count`=0, `Overflow`=0, `Frozen`=0, pointers=0. The memory contents are not reset.

## Timing
- Push-to-read latency is 1 cycle: a word accepted at edge N gives `RdValid`=1 with that word on `RdData` after edge N.
- Pop handshake: the pop completes at the edge where `RdValid & RdReady`=1, and the next word (if any) is presented after that edge.
- The reader may hold `RdReady` high continuously to drain one word per cycle.
- `Frozen` rises the cycle after the matching word is accepted. That word is the last entry written.
- A full FIFO with simultaneous push and pop keeps `Count`=DEPTH, and the pushed word lands in the freed slot.
- `Rst` or `Clear` in any cycle takes effect at that edge; outputs show reset values on the following cycle.

## Structure
- Shared package `trace_pkg`:
  - state enum (`CAPTURE`, `FROZEN`)
  - `TRACE_DEPTH_DEFAULT` = 16
  - `INSTR_W` = 32
- Sub-module `trace_fifo_mem`: a DEPTH×WIDTH array with a synchronous write port and an asynchronous read port.
- The top level owns pointers, count, flags and the FSM.

## Test plan
- Reset, then push 0x20010005, 0x20020003, 0x00221820 on consecutive cycles with `RdReady`=0 → `Count`=3; then drain with `RdReady`=1 → same order, `RdValid` falls after the third pop.
- Push 17 words into DEPTH=16 with no reads → `Count`=16, word 17 dropped, `Overflow`=1; the first pop returns word 1.
- Fill to 16, then push and pop in the same cycle → `Count` stays 16; draining yields words 2–17.
- `TrigEn`=1, `TrigMatch`=0xAC010000, push 0x11111111, 0xAC010000, 0x22222222 → `Count`=2, `Frozen`=1, third word ignored, `Overflow`=0.
- Frozen with 2 words, pulse `Clear` alongside a push → `Count`=0, `Frozen`=0, `Overflow`=0, pushed word discarded; the next push is captured.
- Assert `Rst` mid-drain with `Count`=5 → the next cycle shows `Count`=0, `RdValid`=0 and all flags cleared.
